// File: rtl/video_ram_arbiter.sv
// video_ram_arbiter: 4-phase slot arbiter sharing one SRAM between CRTC video fetch and CPU.
// Define TELETEXT_EN to add the teletext framestore mapping when MA13 is set.
module video_ram_arbiter (
  input  logic        sys_clk,
  input  logic        RESET,
  input  logic [13:0] framestore_adr,
  input  logic [2:0]  char_scanline,
  input  logic        display_en,
  input  logic [1:0]  screen_size,
  input  logic        cpu_req,
  input  logic        cpu_rnw,
  input  logic [14:0] cpu_adr,
  input  logic [7:0]  cpu_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [14:0] ram_adr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  output logic [7:0]  vid_data,
  output logic        vid_strobe,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic        char_en
);
  logic [1:0]  phase_q, phase_d;
  logic [14:0] ram_adr_q, ram_adr_d;
  logic        ram_we_q, ram_we_d;
  logic [7:0]  ram_wdata_q, ram_wdata_d;
  logic [7:0]  vid_data_q, vid_data_d;
  logic        vid_strobe_q, vid_strobe_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        char_en_q, char_en_d;
  logic        disp_q, disp_d;
  logic        grant_q, grant_d;
  logic        rd_q, rd_d;
  logic        grant;
  logic [14:0] wrap, gfx_adr, vid_adr;
`ifndef TELETEXT_EN
  logic        unused_ma13;
  assign unused_ma13 = framestore_adr[13];
`endif
  always_comb begin
    wrap = screen_size == 2'b00 ? 15'h4000 : screen_size == 2'b01 ? 15'h6000 :
           screen_size == 2'b10 ? 15'h3000 : 15'h5800;
    gfx_adr = {framestore_adr[11:0], char_scanline} + (framestore_adr[12] ? wrap : 15'h0000);
`ifdef TELETEXT_EN
    vid_adr = framestore_adr[13] ? {5'b11111, framestore_adr[9:0]} : gfx_adr;
`else
    vid_adr = gfx_adr;
`endif
    grant = phase_q == 2'd1 && cpu_req;
    phase_d = phase_q + 2'd1;
    ram_adr_d = phase_q == 2'd3 ? vid_adr : grant ? cpu_adr : ram_adr_q;
    ram_we_d = grant && !cpu_rnw;
    ram_wdata_d = grant ? cpu_wdata : ram_wdata_q;
    grant_d = grant;
    rd_d = phase_q == 2'd1 ? cpu_req && cpu_rnw : rd_q;
    cpu_ack_d = phase_q == 2'd2 && grant_q;
    cpu_rdata_d = phase_q == 2'd3 && cpu_ack_q && rd_q ? ram_rdata : cpu_rdata_q;
    disp_d = phase_q == 2'd3 ? display_en : disp_q;
    vid_data_d = phase_q == 2'd1 ? ram_rdata : vid_data_q;
    vid_strobe_d = phase_q == 2'd1 && disp_q;
    char_en_d = phase_q == 2'd2;
  end
  always_ff @(posedge sys_clk) begin
    if (RESET) begin
      phase_q      <= 2'd0;
      ram_adr_q    <= '0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= '0;
      vid_data_q   <= '0;
      vid_strobe_q <= 1'b0;
      cpu_rdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      char_en_q    <= 1'b0;
      disp_q       <= 1'b0;
      grant_q      <= 1'b0;
      rd_q         <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      ram_adr_q    <= ram_adr_d;
      ram_we_q     <= ram_we_d;
      ram_wdata_q  <= ram_wdata_d;
      vid_data_q   <= vid_data_d;
      vid_strobe_q <= vid_strobe_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_ack_q    <= cpu_ack_d;
      char_en_q    <= char_en_d;
      disp_q       <= disp_d;
      grant_q      <= grant_d;
      rd_q         <= rd_d;
    end
  end
  assign ram_adr    = ram_adr_q;
  assign ram_we     = ram_we_q;
  assign ram_wdata  = ram_wdata_q;
  assign vid_data   = vid_data_q;
  assign vid_strobe = vid_strobe_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_ack    = cpu_ack_q;
  assign char_en    = char_en_q;
endmodule

// File: tb/tb_video_ram_arbiter.sv
// tb_video_ram_arbiter: directed scoreboard bench for video_ram_arbiter with a synchronous SRAM model.
module tb_video_ram_arbiter;
  logic        sys_clk = 1'b0;
  logic        RESET = 1'b1;
  logic [13:0] framestore_adr = '0;
  logic [2:0]  char_scanline = '0;
  logic        display_en = 1'b0;
  logic [1:0]  screen_size = '0;
  logic        cpu_req = 1'b0;
  logic        cpu_rnw = 1'b1;
  logic [14:0] cpu_adr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  ram_rdata;
  logic [14:0] ram_adr;
  logic        ram_we;
  logic [7:0]  ram_wdata, vid_data, cpu_rdata;
  logic        vid_strobe, cpu_ack, char_en;
  logic [7:0]  mem [0:32767];
  logic [63:0] exp_q [$];
  logic [14:0] wraps [4] = '{15'h4000, 15'h6000, 15'h3000, 15'h5800};
  logic [14:0] xa;
  int tests = 0, fails = 0, ph = 0, we_bad = 0, n = 0, acks = 0;
  always #5 sys_clk = ~sys_clk;
  video_ram_arbiter dut (
    .sys_clk(sys_clk), .RESET(RESET), .framestore_adr(framestore_adr),
    .char_scanline(char_scanline), .display_en(display_en), .screen_size(screen_size),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .ram_rdata(ram_rdata), .ram_adr(ram_adr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .vid_data(vid_data), .vid_strobe(vid_strobe), .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack), .char_en(char_en)
  );
  always @(posedge sys_clk) begin
    if (ram_we) mem[ram_adr] <= ram_wdata;
    ram_rdata <= mem[ram_adr];
  end
  function automatic logic [7:0] pat(int a);
    return 8'(a ^ (a >> 7) ^ 8'h3C);
  endfunction
  task automatic tick();
    logic r;
    r = RESET;
    @(posedge sys_clk);
    #1;
    ph = r ? 0 : (ph + 1) % 4;
    if (ram_we && ph != 2) we_bad++;
  endtask
  task automatic chk(string tag, logic [63:0] obs);
    logic [63:0] e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL %s scoreboard empty, observed %h", tag, obs);
      return;
    end
    e = exp_q.pop_front();
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s observed %h expected %h", tag, obs, e);
    end
  endtask
  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    for (int a = 0; a < 32768; a++) mem[a] = pat(a);
    framestore_adr = 14'h0123;
    char_scanline = 3'd5;
    display_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_q.push_back(64'd0);
      chk("reset_outputs", {ram_adr, ram_we, ram_wdata, vid_data, vid_strobe, cpu_rdata, cpu_ack, char_en});
    end
    RESET = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(64'(i == 4));
      chk("char_en_cycle", char_en);
      if (i < 4) tick();
    end
    tick();
    exp_q.push_back(15'h091D);
    chk("vid_adr_ph0", ram_adr);
    exp_q.push_back(0);
    chk("vid_we_ph0", ram_we);
    tick();
    tick();
    exp_q.push_back(pat(15'h091D));
    chk("vid_data", vid_data);
    exp_q.push_back(1);
    chk("vid_strobe_ph2", vid_strobe);
    tick();
    exp_q.push_back(0);
    chk("vid_strobe_ph3", vid_strobe);
    display_en = 1'b0;
    framestore_adr = 14'h1F00;
    char_scanline = 3'd0;
    for (int s = 0; s < 4; s++) begin
      screen_size = 2'(s);
      xa = 15'(15'h7800 + wraps[s]);
      tick();
      exp_q.push_back(xa);
      chk("wrap_adr", ram_adr);
      tick();
      tick();
      exp_q.push_back(pat(xa));
      chk("wrap_vid_data", vid_data);
      exp_q.push_back(0);
      chk("no_strobe_disp_off", vid_strobe);
      tick();
    end
    framestore_adr = 14'h2345;
    char_scanline = 3'd3;
`ifdef TELETEXT_EN
    xa = 15'h7F45;
`else
    xa = {12'h345, 3'd3};
`endif
    tick();
    exp_q.push_back(xa);
    chk("ma13_adr", ram_adr);
    tick();
    tick();
    exp_q.push_back(pat(xa));
    chk("ma13_vid_data", vid_data);
    cpu_req = 1'b1;
    cpu_rnw = 1'b0;
    cpu_adr = 15'h3000;
    cpu_wdata = 8'hA5;
    n = 0;
    while (!cpu_ack && n < 8) begin
      tick();
      n++;
      if (n == 4) begin
        exp_q.push_back({15'h3000, 1'b1, 8'hA5});
        chk("cpu_wr_bus", {ram_adr, ram_we, ram_wdata});
      end
    end
    exp_q.push_back(5);
    chk("wr_ack_latency", n);
    cpu_rnw = 1'b1;
    n = 0;
    while (!cpu_ack || n == 0) begin
      tick();
      n++;
      if (n == 1) begin
        exp_q.push_back(0);
        chk("wr_rdata_hold", cpu_rdata);
      end
      if (n >= 8) break;
    end
    exp_q.push_back(4);
    chk("rd_ack_latency", n);
    cpu_adr = 15'h0005;
    tick();
    exp_q.push_back(8'hA5);
    chk("rd_data_3000", cpu_rdata);
    n = 1;
    while (!cpu_ack && n < 8) begin
      tick();
      n++;
    end
    exp_q.push_back(4);
    chk("held_req_ack_latency", n);
    cpu_req = 1'b0;
    tick();
    exp_q.push_back(pat(5));
    chk("rd_data_0005", cpu_rdata);
    cpu_req = 1'b1;
    cpu_rnw = 1'b0;
    cpu_adr = 15'h0100;
    cpu_wdata = 8'h5A;
    tick();
    tick();
    exp_q.push_back(1);
    chk("rst_mid_we_granted", ram_we);
    RESET = 1'b1;
    cpu_req = 1'b0;
    tick();
    exp_q.push_back(0);
    chk("rst_mid_bus", {ram_we, cpu_ack, ram_adr, ram_wdata});
    tick();
    exp_q.push_back(0);
    chk("rst_mid_no_ack", cpu_ack);
    RESET = 1'b0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cpu_ack) acks++;
    end
    exp_q.push_back(0);
    chk("rst_abort_acks", acks);
    exp_q.push_back(0);
    chk("we_outside_ph2", we_bad);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
